instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the register/ALU datapath.
- Drives the program counter and a req/ack instruction-memory handshake, and strobes the instruction register load.
- Classifies each opcode, then sequences the ALU select, immediate mux select and register-file write enable over fixed phases.
- Replaces the single opcode-to-control mapping with a block that also owns instruction fetch, halt and stall behaviour.

Parameters:
- PC_WIDTH, 8, program counter / instruction address width.
- WIDTH_OPCODE, 10, opcode field width from instruction decode.
- ALU_OP_WIDTH, 5, width of ALU operation select.
- START_ADDR, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- opcode  input  WIDTH_OPCODE  opcode of the currently held instruction.
- mem_ack  input  1  instruction memory has valid data on the bus this cycle.
- mem_req  output  1  instruction fetch request.
- pc  output  PC_WIDTH  fetch address, valid while mem_req=1.
- control_instruction  output  1  instruction register load enable.
- imm_select  output  1  0 selects immediate, 1 selects ALU result for write data.
- write_enable  output  1  register file write strobe.
- aluOP  output  ALU_OP_WIDTH  ALU operation select.
- halted  output  1  sequencer stopped on HALT.
- step  input  1  single-step advance; present only with STEP_MODE_EN.

Behaviour:
- Reset (reset=0 at a clk edge): state=FETCH, pc=START_ADDR.
  - Outputs forced to: mem_req=0, control_instruction=0, write_enable=0, imm_select=1, aluOP=0, halted=0.
  - Reset overrides every state, including mid-handshake and HALT.
- Opcode class is opcode[WIDTH_OPCODE-1:WIDTH_OPCODE-2]:
  - 00 ALU: aluOP=opcode[ALU_OP_WIDTH-1:0].
  - 01 LDI: load immediate.
  - 10 NOP.
  - 11 HALT.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - mem_req=1, pc stable.
  - On mem_ack=1: control_instruction=1 for exactly that cycle, then go to DECODE.
  - While mem_ack=0: remain in FETCH, no timeout.
  - mem_ack outside FETCH is ignored.
- DECODE: one cycle, all strobes low, opcode sampled into an internal class register.
- EXECUTE:
  - ALU: aluOP driven, imm_select=1, go to WRITEBACK.
  - LDI: imm_select=0, go to WRITEBACK.
  - NOP: pc<=pc+1, go to FETCH.
  - HALT: go to HALT; pc is not incremented.
- WRITEBACK:
  - write_enable=1 for exactly one cycle.
  - aluOP and imm_select held at their EXECUTE values.
  - pc<=pc+1, go to FETCH.
- aluOP and imm_select are registered and hold their value until the next EXECUTE or reset.
- HALT: halted=1, all strobes low, mem_req=0; exits only via reset.
- Latency:
  - ALU/LDI instruction = 4 cycles with zero-wait memory (FETCH, DECODE, EXECUTE, WRITEBACK).
  - NOP = 3 cycles.
- pc arithmetic: modulo 2^PC_WIDTH; all-ones wraps to 0 silently.
- write_enable and control_instruction are never high in the same cycle.
- At most one write_enable pulse per instruction.

Optional Feature:
- Macro: STEP_MODE_EN.
- Defined:
  - Adds the step input and a PAUSE state entered after WRITEBACK and after the NOP EXECUTE, in place of going straight to FETCH.
  - PAUSE: all strobes low; a cycle with step=1 moves to FETCH.
  - step is level-sampled, so holding it high runs freely with one extra cycle per instruction.
  - pc has already been incremented on entry to PAUSE.
  - Reset in PAUSE returns to FETCH normally.
- Undefined: no step port and no PAUSE state; behaviour exactly as above.

Test Plan:
- Reset with mem_ack tied 1 and opcode=10'h003 (ALU, op 3):
  - aluOP=3 and imm_select=1 in EXECUTE.
  - write_enable pulses in cycle 4.
  - pc 0->1; second fetch starts cycle 5.
- mem_ack held 0 for 5 cycles then 1:
  - mem_req stays high with pc constant.
  - control_instruction pulses once, in the ack cycle only.
- opcode=10'h100 (LDI): imm_select=0 during WRITEBACK, write_enable for one cycle.
- opcode=10'h200 (NOP) then 10'h300 (HALT):
  - NOP: no write_enable, pc 0->1.
  - HALT: halted=1 and mem_req=0 from the cycle after its EXECUTE; pc stays 1 for 20 cycles.
- pc preset via START_ADDR=255 with ALU instruction: pc wraps to 0 after WRITEBACK.
- reset=0 asserted during WRITEBACK and during HALT:
  - Next cycle all outputs at reset values, pc=START_ADDR, FETCH resumes.
- With STEP_MODE_EN: after the first ALU instruction the sequencer holds PAUSE with mem_req=0 until step=1, then fetches pc=1.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
interface instr_sequencer_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                mem_req;
  logic                mem_ack;
  logic [PC_WIDTH-1:0] pc;

  modport master (output mem_req, output pc, input mem_ack);
  modport slave  (input mem_req, input pc, output mem_ack);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with req/ack instruction fetch.
// Optional single-step PAUSE state when STEP_MODE_EN is defined.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned WIDTH_OPCODE = 10,
  parameter int unsigned ALU_OP_WIDTH = 5,
  parameter int unsigned START_ADDR   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  instr_sequencer_if.master       fetch,
  input  logic [WIDTH_OPCODE-1:0] opcode,
  output logic                    control_instruction,
  output logic                    imm_select,
  output logic                    write_enable,
  output logic [ALU_OP_WIDTH-1:0] aluOP,
`ifdef STEP_MODE_EN
  output logic                    halted,
  input  logic                    step
`else
  output logic                    halted
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
`ifdef STEP_MODE_EN
    , S_PAUSE
`endif
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LDI  = 2'b01,
    CLS_NOP  = 2'b10,
    CLS_HALT = 2'b11
  } class_t;

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);
`ifdef STEP_MODE_EN
  localparam state_t AFTER_INSTR = S_PAUSE;
`else
  localparam state_t AFTER_INSTR = S_FETCH;
`endif

  state_t                  state, state_next;
  class_t                  cls_q;
  logic [ALU_OP_WIDTH-1:0] op_q;
  logic [ALU_OP_WIDTH-1:0] alu_q, alu_next;
  logic                    imm_q, imm_next;
  logic [PC_WIDTH-1:0]     pc_q, pc_next;
  logic                    req_c, ci_c, we_c, halt_c;
  logic                    unused_opcode_bits;

  assign unused_opcode_bits = ^opcode;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      pc_q  <= START_PC;
      cls_q <= CLS_ALU;
      op_q  <= '0;
      alu_q <= '0;
      imm_q <= 1'b1;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      alu_q <= alu_next;
      imm_q <= imm_next;
      if (state == S_DECODE) begin
        cls_q <= class_t'(opcode[WIDTH_OPCODE-1:WIDTH_OPCODE-2]);
        op_q  <= opcode[ALU_OP_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    alu_next   = alu_q;
    imm_next   = imm_q;
    req_c      = 1'b0;
    ci_c       = 1'b0;
    we_c       = 1'b0;
    halt_c     = 1'b0;
    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (fetch.mem_ack) begin
          ci_c       = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        case (cls_q)
          CLS_ALU: begin
            alu_next   = op_q;
            imm_next   = 1'b1;
            state_next = S_WRITEBACK;
          end
          CLS_LDI: begin
            imm_next   = 1'b0;
            state_next = S_WRITEBACK;
          end
          CLS_NOP: begin
            pc_next    = pc_q + 1'b1;
            state_next = AFTER_INSTR;
          end
          default: state_next = S_HALT;
        endcase
      end
      S_WRITEBACK: begin
        we_c       = 1'b1;
        pc_next    = pc_q + 1'b1;
        state_next = AFTER_INSTR;
      end
      S_HALT: halt_c = 1'b1;
`ifdef STEP_MODE_EN
      S_PAUSE: if (step) state_next = S_FETCH;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // aluOP/imm_select show the new value already in EXECUTE and the register holds it afterwards;
  // while reset is low every output is forced to its reset value.
  assign fetch.mem_req       = reset & req_c;
  assign fetch.pc            = reset ? pc_q : START_PC;
  assign control_instruction = reset & ci_c;
  assign write_enable        = reset & we_c;
  assign halted              = reset & halt_c;
  assign aluOP               = reset ? alu_next : '0;
  assign imm_select          = reset ? imm_next : 1'b1;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (two instances: START_ADDR 0 and 255).
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ack;
  logic [9:0] opcode;
  logic       step;
  int         checks = 0;
  int         errors = 0;

  logic       ci0, imm0, we0, halted0;
  logic [4:0] alu0;
  logic       ci1, imm1, we1, halted1;
  logic [4:0] alu1;

  instr_sequencer_if #(.PC_WIDTH(8)) bus0 ();
  instr_sequencer_if #(.PC_WIDTH(8)) bus1 ();
  assign bus0.mem_ack = mem_ack;
  assign bus1.mem_ack = mem_ack;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_WIDTH(8), .WIDTH_OPCODE(10), .ALU_OP_WIDTH(5), .START_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .fetch(bus0.master), .opcode(opcode),
    .control_instruction(ci0), .imm_select(imm0), .write_enable(we0),
`ifdef STEP_MODE_EN
    .aluOP(alu0), .halted(halted0), .step(step)
`else
    .aluOP(alu0), .halted(halted0)
`endif
  );

  instr_sequencer #(.PC_WIDTH(8), .WIDTH_OPCODE(10), .ALU_OP_WIDTH(5), .START_ADDR(255)) dut1 (
    .clk(clk), .reset(reset), .fetch(bus1.master), .opcode(opcode),
    .control_instruction(ci1), .imm_select(imm1), .write_enable(we1),
`ifdef STEP_MODE_EN
    .aluOP(alu1), .halted(halted1), .step(step)
`else
    .aluOP(alu1), .halted(halted1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b1; opcode = 10'h003; step = 1'b0;
    tick();
    chk("rst_req", 32'(bus0.mem_req), 32'd0);
    chk("rst_pc", 32'(bus0.pc), 32'd0);
    chk("rst_ci", 32'(ci0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_imm", 32'(imm0), 32'd1);
    chk("rst_alu", 32'(alu0), 32'd0);
    chk("rst_halted", 32'(halted0), 32'd0);
    chk("rst_pc255", 32'(bus1.pc), 32'd255);
    reset = 1'b1;
    #1;
`ifndef STEP_MODE_EN
    // ALU op 3, zero-wait memory
    chk("alu_c1_req", 32'(bus0.mem_req), 32'd1);
    chk("alu_c1_ci", 32'(ci0), 32'd1);
    chk("alu_c1_we", 32'(we0), 32'd0);
    tick();
    chk("alu_c2_ci", 32'(ci0), 32'd0);
    chk("alu_c2_req", 32'(bus0.mem_req), 32'd0);
    chk("alu_c2_we", 32'(we0), 32'd0);
    tick();
    chk("alu_c3_alu", 32'(alu0), 32'd3);
    chk("alu_c3_imm", 32'(imm0), 32'd1);
    chk("alu_c3_we", 32'(we0), 32'd0);
    tick();
    chk("alu_c4_we", 32'(we0), 32'd1);
    chk("alu_c4_ci", 32'(ci0), 32'd0);
    chk("alu_c4_alu", 32'(alu0), 32'd3);
    chk("alu_c4_pc255", 32'(bus1.pc), 32'd255);
    tick();
    chk("alu_c5_pc", 32'(bus0.pc), 32'd1);
    chk("alu_c5_req", 32'(bus0.mem_req), 32'd1);
    chk("alu_c5_we", 32'(we0), 32'd0);
    chk("wrap_pc", 32'(bus1.pc), 32'd0);

    // LDI with 5 wait cycles
    mem_ack = 1'b0; opcode = 10'h100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wait_req", 32'(bus0.mem_req), 32'd1);
      chk("wait_pc", 32'(bus0.pc), 32'd1);
      chk("wait_ci", 32'(ci0), 32'd0);
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("ack_ci", 32'(ci0), 32'd1);
    chk("ack_req", 32'(bus0.mem_req), 32'd1);
    tick();
    chk("ldi_dec_ci", 32'(ci0), 32'd0);
    tick();
    chk("ldi_ex_imm", 32'(imm0), 32'd0);
    tick();
    chk("ldi_wb_imm", 32'(imm0), 32'd0);
    chk("ldi_wb_we", 32'(we0), 32'd1);
    tick();
    chk("ldi_next_we", 32'(we0), 32'd0);
    chk("ldi_next_pc", 32'(bus0.pc), 32'd2);
    chk("ldi_hold_imm", 32'(imm0), 32'd0);

    // NOP then HALT
    opcode = 10'h200;
    tick();
    tick();
    chk("nop_ex_we", 32'(we0), 32'd0);
    tick();
    chk("nop_pc", 32'(bus0.pc), 32'd3);
    chk("nop_req", 32'(bus0.mem_req), 32'd1);
    opcode = 10'h300;
    tick();
    tick();
    chk("halt_ex_halted", 32'(halted0), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_halted", 32'(halted0), 32'd1);
      chk("halt_req", 32'(bus0.mem_req), 32'd0);
      chk("halt_pc", 32'(bus0.pc), 32'd3);
      chk("halt_we", 32'(we0), 32'd0);
      tick();
    end

    // reset during HALT
    reset = 1'b0;
    tick();
    chk("rsth_halted", 32'(halted0), 32'd0);
    chk("rsth_pc", 32'(bus0.pc), 32'd0);
    chk("rsth_req", 32'(bus0.mem_req), 32'd0);
    chk("rsth_imm", 32'(imm0), 32'd1);
    chk("rsth_alu", 32'(alu0), 32'd0);
    reset = 1'b1;
    opcode = 10'h01f;
    #1;
    chk("rsth_fetch_req", 32'(bus0.mem_req), 32'd1);
    chk("rsth_fetch_ci", 32'(ci0), 32'd1);

    // reset during WRITEBACK
    tick();
    tick();
    chk("alu31_ex", 32'(alu0), 32'd31);
    tick();
    chk("alu31_wb_we", 32'(we0), 32'd1);
    reset = 1'b0;
    tick();
    chk("rstw_pc", 32'(bus0.pc), 32'd0);
    chk("rstw_alu", 32'(alu0), 32'd0);
    chk("rstw_we", 32'(we0), 32'd0);
    chk("rstw_imm", 32'(imm0), 32'd1);
    chk("rstw_req", 32'(bus0.mem_req), 32'd0);
    reset = 1'b1;
    #1;
    chk("rstw_fetch_req", 32'(bus0.mem_req), 32'd1);
    chk("rstw_fetch_pc", 32'(bus0.pc), 32'd0);
`else
    // single-step: PAUSE after the first ALU instruction
    tick();
    tick();
    chk("step_ex_alu", 32'(alu0), 32'd3);
    tick();
    chk("step_wb_we", 32'(we0), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("pause_req", 32'(bus0.mem_req), 32'd0);
      chk("pause_pc", 32'(bus0.pc), 32'd1);
      chk("pause_we", 32'(we0), 32'd0);
      tick();
    end
    step = 1'b1;
    tick();
    chk("step_fetch_req", 32'(bus0.mem_req), 32'd1);
    chk("step_fetch_pc", 32'(bus0.pc), 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
